// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter.
// The WAIT-state timeout in spi_arb is enabled by defining SPI_TIMEOUT_EN.
package spi_arb_pkg;

  localparam int IDX_W = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    DONE   = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam logic [2:0] SS_TRIG = 3'b000;
  localparam logic [2:0] SS_CH1  = 3'b001;
  localparam logic [2:0] SS_CH2  = 3'b010;
  localparam logic [2:0] SS_CH3  = 3'b011;
  localparam logic [2:0] SS_EEP  = 3'b100;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin picker: the pending requester nearest after
// i_last in cyclic order wins.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Smallest cyclic distance from the last-granted index wins
  always_comb begin
    int   w_dist;
    int   w_best;
    logic w_cand;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = |i_req;
    w_best  = NREQ;
    w_dist  = 0;
    w_cand  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      w_dist = j - int'(i_last) - 1;
      w_dist = (w_dist < 0) ? (w_dist + NREQ) : w_dist;
      w_cand = i_req[j] && (w_dist < w_best);
      w_best = w_cand ? w_dist : w_best;
      o_idx  = w_cand ? IDX_W'(j) : o_idx;
      o_gnt  = w_cand ? (NREQ'(1) << j) : o_gnt;
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter/sequencer sharing one SPI master among NREQ requesters.
// Define SPI_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYC cycles.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [3*NREQ-1:0]    req_ss,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [7:0]           rd_data,
  output logic [2:0]           ss,
  output logic [15:0]          SPI_data,
  output logic                 wrt_SPI,
  input  logic                 SPI_done,
  input  logic [7:0]           EEP_data
);

  state_t           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [NREQ-1:0]  r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             r_wrt, w_wrt_nxt;
  logic [2:0]       r_ss, w_ss_nxt;
  logic [15:0]      r_data, w_data_nxt;
  logic [7:0]       r_rd, w_rd_nxt;
  logic [IDX_W-1:0] r_last, w_last_nxt;
  logic [IDX_W-1:0] r_cur, w_cur_nxt;
  logic [3:0]       r_gap, w_gap_nxt;

  logic [NREQ-1:0]  w_pick_gnt;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_valid;
  logic [2:0]       w_pick_ss;
  logic [15:0]      w_pick_data;
  logic             w_expired;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // One-hot mux of the winning requester's slave select and data word
  always_comb begin
    w_pick_ss   = '0;
    w_pick_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_pick_ss   = w_pick_ss   | ({3{w_pick_gnt[j]}}  & req_ss[3*j +: 3]);
      w_pick_data = w_pick_data | ({16{w_pick_gnt[j]}} & req_data[16*j +: 16]);
    end
  end

`ifdef SPI_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] r_wcnt;

  // WAIT-cycle counter, cleared while launching so WAIT starts at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (r_state == LAUNCH) begin
      r_wcnt <= '0;
    end else if (r_state == WAIT) begin
      r_wcnt <= r_wcnt + TW'(1);
    end else begin
      r_wcnt <= r_wcnt;
    end
  end

  assign w_expired = (r_wcnt == TW'(TIMEOUT_CYC - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC > 0);
  assign w_expired    = 1'b0;
`endif

  // Next-state and next-output logic; outputs are computed one cycle ahead
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_err_nxt   = 1'b0;
    w_wrt_nxt   = 1'b0;
    w_ss_nxt    = r_ss;
    w_data_nxt  = r_data;
    w_rd_nxt    = r_rd;
    w_last_nxt  = r_last;
    w_cur_nxt   = r_cur;
    w_gap_nxt   = r_gap;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = LAUNCH;
          w_gnt_nxt   = w_pick_gnt;
          w_ss_nxt    = w_pick_ss;
          w_data_nxt  = w_pick_data;
          w_cur_nxt   = w_pick_idx;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LAUNCH: begin
        w_wrt_nxt   = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // A completion on the expiry cycle takes priority over the timeout
        if (SPI_done) begin
          w_rd_nxt    = EEP_data;
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = '0;
          w_state_nxt = DONE;
        end else if (w_expired) begin
          w_rd_nxt    = 8'hFF;
          w_err_nxt   = 1'b1;
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = '0;
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      DONE: begin
        w_last_nxt  = r_cur;
        w_gap_nxt   = 4'(GAP_CYC - 1);
        w_state_nxt = GAP;
      end
      GAP: begin
        if (r_gap == 4'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_wrt   <= 1'b0;
      r_ss    <= 3'b000;
      r_data  <= 16'h0000;
      r_rd    <= 8'h00;
      r_last  <= IDX_W'(NREQ - 1);
      r_cur   <= '0;
      r_gap   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_wrt   <= w_wrt_nxt;
      r_ss    <= w_ss_nxt;
      r_data  <= w_data_nxt;
      r_rd    <= w_rd_nxt;
      r_last  <= w_last_nxt;
      r_cur   <= w_cur_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign err      = r_err;
  assign wrt_SPI  = r_wrt;
  assign ss       = r_ss;
  assign SPI_data = r_data;
  assign rd_data  = r_rd;

endmodule
